// File: rtl/bus_ack_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_ack_ctrl_if
// Bundles the 68000-side bus-cycle signals seen by the cycle-termination stage.
//   as, uds, lds         address / data strobes, active low
//   fc[2:0]              function code (3'b111 = interrupt acknowledge)
//   ram_select1/2        RAM bank selects from the decoder, active low
//   rom_select           ROM select from the decoder, active low
//   single_step          high = hold every cycle until a step press
//   step_btn             raw front-panel step pushbutton, active high
//   dtack, berr, vpa     cycle terminations back to the CPU, active low
// Modports:
//   slave  - the termination controller (consumes strobes, drives acks)
//   master - the CPU/decoder side (drives strobes, observes acks)
// ---------------------------------------------------------------------------
interface bus_ack_ctrl_if;
    logic       as;
    logic       uds;
    logic       lds;
    logic [2:0] fc;
    logic       ram_select1;
    logic       ram_select2;
    logic       rom_select;
    logic       single_step;
    logic       step_btn;
    logic       dtack;
    logic       berr;
    logic       vpa;

    modport slave (
        input  as, uds, lds, fc,
        input  ram_select1, ram_select2, rom_select,
        input  single_step, step_btn,
        output dtack, berr, vpa
    );

    modport master (
        output as, uds, lds, fc,
        output ram_select1, ram_select2, rom_select,
        output single_step, step_btn,
        input  dtack, berr, vpa
    );
endinterface

// File: rtl/bus_ack_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ack_ctrl
// 68000 bus-cycle termination stage sitting behind the address decoder.
// Adds per-device wait states before DTACK, a watchdog that raises BERR on
// unmapped or hung cycles, autovectored IACK via VPA, and a single-step hold
// for front-panel debugging.
// Ports:
//   cpu_clk  in  CPU clock, all state on the rising edge
//   reset    in  asynchronous active-high reset
//   bus      slave modport of bus_ack_ctrl_if (strobes in, dtack/berr/vpa out)
// All outputs are registered and idle high.
// ---------------------------------------------------------------------------
module bus_ack_ctrl #(
    parameter int ROM_WAIT     = 2,
    parameter int RAM_WAIT     = 0,
    parameter int BERR_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic           cpu_clk,
    input  logic           reset,
    bus_ack_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP_HOLD,
        ST_ACK,
        ST_BERR,
        ST_IACK
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   wait_q;
    logic [CNT_W-1:0]   wd_q;
    logic [CNT_W-1:0]   wd_d;
    logic               mapped_q;   // cycle has a device that will eventually DTACK
    logic               armed_q;    // an IDLE edge with as high has been seen
    logic               dtack_q;
    logic               berr_q;
    logic               vpa_q;

    logic               step_sync1_q;
    logic               step_sync2_q;
    logic               step_prev_q;
    logic               step_pulse;
    logic               cycle_start;

    // Step button synchronizer and rising-edge detector.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            step_sync1_q <= 1'b0;
            step_sync2_q <= 1'b0;
            step_prev_q  <= 1'b0;
        end else begin
            step_sync1_q <= bus.step_btn;
            step_sync2_q <= step_sync1_q;
            step_prev_q  <= step_sync2_q;
        end
    end

    assign step_pulse  = step_sync2_q & ~step_prev_q;

    // IACK cycles may run with both data strobes high, so fc alone also starts.
    assign cycle_start = ~bus.as & (~bus.uds | ~bus.lds | (bus.fc == 3'b111));

    // Watchdog saturates at all-ones so a very long hold can never wrap it.
    assign wd_d = (wd_q == {CNT_W{1'b1}}) ? wd_q : wd_q + 1'b1;

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            wd_q     <= '0;
            mapped_q <= 1'b0;
            armed_q  <= 1'b1;
            dtack_q  <= 1'b1;
            berr_q   <= 1'b1;
            vpa_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dtack_q <= 1'b1;
                    berr_q  <= 1'b1;
                    vpa_q   <= 1'b1;
                    if (bus.as) begin
                        armed_q <= 1'b1;
                    end else if (armed_q && cycle_start) begin
                        wd_q <= '0;
                        if (bus.fc == 3'b111) begin
                            state_q <= ST_IACK;
                        end else if (!bus.rom_select) begin
                            wait_q   <= CNT_W'(ROM_WAIT);
                            mapped_q <= 1'b1;
                            state_q  <= ST_WAIT;
                        end else if (!bus.ram_select1 || !bus.ram_select2) begin
                            wait_q   <= CNT_W'(RAM_WAIT);
                            mapped_q <= 1'b1;
                            state_q  <= ST_WAIT;
                        end else begin
                            // Unmapped: nothing will answer, only the watchdog ends it.
                            wait_q   <= '0;
                            mapped_q <= 1'b0;
                            state_q  <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (bus.as) begin
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (mapped_q && (wait_q == '0)) begin
                        // Checked before the watchdog so a same-cycle expiry acks.
                        if (bus.single_step) begin
                            state_q <= ST_STEP_HOLD;
                        end else begin
                            dtack_q <= 1'b0;
                            state_q <= ST_ACK;
                        end
                    end else begin
                        if (wait_q != '0) begin
                            wait_q <= wait_q - 1'b1;
                        end
                        wd_q <= wd_d;
                        if (wd_d >= CNT_W'(BERR_TIMEOUT)) begin
                            berr_q  <= 1'b0;
                            state_q <= ST_BERR;
                        end
                    end
                end

                ST_STEP_HOLD: begin
                    if (bus.as) begin
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (step_pulse || !bus.single_step) begin
                        dtack_q <= 1'b0;
                        state_q <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    if (bus.as) begin
                        dtack_q <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_BERR: begin
                    if (bus.as) begin
                        berr_q  <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_IACK: begin
                    if (bus.as) begin
                        vpa_q   <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        vpa_q <= 1'b0;
                    end
                end

                default: begin
                    dtack_q <= 1'b1;
                    berr_q  <= 1'b1;
                    vpa_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dtack = dtack_q;
    assign bus.berr  = berr_q;
    assign bus.vpa   = vpa_q;

endmodule

// File: tb/tb_bus_ack_ctrl.sv
module tb_bus_ack_ctrl;

    logic cpu_clk = 1'b0;
    logic reset   = 1'b1;
    int   tests   = 0;
    int   fails   = 0;

    bus_ack_ctrl_if bus ();

    bus_ack_ctrl #(
        .ROM_WAIT     (2),
        .RAM_WAIT     (0),
        .BERR_TIMEOUT (64),
        .CNT_W        (8)
    ) dut (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.as          = 1'b1;
        bus.uds         = 1'b1;
        bus.lds         = 1'b1;
        bus.fc          = 3'b101;
        bus.ram_select1 = 1'b1;
        bus.ram_select2 = 1'b1;
        bus.rom_select  = 1'b1;
    endtask

    // Release strobes and give the controller its re-arming IDLE edge.
    task automatic end_cycle();
        idle_bus();
        tick();
        tick();
    endtask

    task automatic test_reset();
        idle_bus();
        bus.single_step = 1'b0;
        bus.step_btn    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL reset_dtack: got %b want 1", bus.dtack); end
        tests++; if (bus.berr  !== 1'b1) begin fails++; $display("FAIL reset_berr: got %b want 1", bus.berr); end
        tests++; if (bus.vpa   !== 1'b1) begin fails++; $display("FAIL reset_vpa: got %b want 1", bus.vpa); end
        reset = 1'b0;
        tick();
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_rom_read();
        bus.as = 1'b0; bus.uds = 1'b0; bus.rom_select = 1'b0;
        // Edge 1 recognises the start; dtack falls 3 edges after it.
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests++; if (bus.dtack !== ((k >= 4) ? 1'b0 : 1'b1)) begin fails++; $display("FAIL rom_dtack edge %0d: got %b want %b", k, bus.dtack, (k >= 4) ? 1'b0 : 1'b1); end
            tests++; if (bus.berr !== 1'b1 || bus.vpa !== 1'b1) begin fails++; $display("FAIL rom_berr_vpa edge %0d: got %b%b want 11", k, bus.berr, bus.vpa); end
        end
        bus.as = 1'b1;
        tick();
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL rom_release: got %b want 1", bus.dtack); end
        end_cycle();
        $display("[TB] test_rom_read done");
    endtask

    task automatic test_ram(input int bank);
        bus.as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
        if (bank == 1) bus.ram_select1 = 1'b0;
        else           bus.ram_select2 = 1'b0;
        tick();
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL ram%0d_start: got %b want 1", bank, bus.dtack); end
        tick();
        tests++; if (bus.dtack !== 1'b0) begin fails++; $display("FAIL ram%0d_ack: got %b want 0", bank, bus.dtack); end
        bus.as = 1'b1;
        tick();
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL ram%0d_release: got %b want 1", bank, bus.dtack); end
        end_cycle();
        $display("[TB] test_ram bank %0d done", bank);
    endtask

    task automatic test_priority();
        // ROM and RAM1 together must take the ROM wait states.
        bus.as = 1'b0; bus.uds = 1'b0; bus.rom_select = 1'b0; bus.ram_select1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++; if (bus.dtack !== ((k == 4) ? 1'b0 : 1'b1)) begin fails++; $display("FAIL prio_dtack edge %0d: got %b want %b", k, bus.dtack, (k == 4) ? 1'b0 : 1'b1); end
        end
        end_cycle();
        $display("[TB] test_priority done");
    endtask

    task automatic test_unmapped();
        bus.as = 1'b0; bus.lds = 1'b0;
        // Start edge plus 64 watchdog cycles: berr falls on edge 65.
        for (int k = 1; k <= 67; k++) begin
            tick();
            tests++; if (bus.berr !== ((k >= 65) ? 1'b0 : 1'b1)) begin fails++; $display("FAIL unmapped_berr edge %0d: got %b want %b", k, bus.berr, (k >= 65) ? 1'b0 : 1'b1); end
            tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL unmapped_dtack edge %0d: got %b want 1", k, bus.dtack); end
        end
        bus.as = 1'b1;
        tick();
        tests++; if (bus.berr !== 1'b1) begin fails++; $display("FAIL unmapped_release: got %b want 1", bus.berr); end
        end_cycle();
        $display("[TB] test_unmapped done");
    endtask

    task automatic test_iack();
        bus.as = 1'b0; bus.fc = 3'b111;
        tick();
        tests++; if (bus.vpa !== 1'b1) begin fails++; $display("FAIL iack_start: got %b want 1", bus.vpa); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            tests++; if (bus.vpa !== 1'b0) begin fails++; $display("FAIL iack_vpa edge %0d: got %b want 0", k, bus.vpa); end
            tests++; if (bus.dtack !== 1'b1 || bus.berr !== 1'b1) begin fails++; $display("FAIL iack_others edge %0d: got %b%b want 11", k, bus.dtack, bus.berr); end
        end
        bus.as = 1'b1;
        tick();
        tests++; if (bus.vpa !== 1'b1) begin fails++; $display("FAIL iack_release: got %b want 1", bus.vpa); end
        end_cycle();
        $display("[TB] test_iack done");
    endtask

    task automatic test_single_step();
        bus.single_step = 1'b1;
        bus.as = 1'b0; bus.uds = 1'b0; bus.rom_select = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            tests++; if (bus.dtack !== 1'b1 || bus.berr !== 1'b1) begin fails++; $display("FAIL step_hold edge %0d: dtack/berr %b%b want 11", k, bus.dtack, bus.berr); end
        end
        bus.step_btn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests++; if (bus.dtack !== ((k == 3) ? 1'b0 : 1'b1)) begin fails++; $display("FAIL step_ack edge %0d: got %b want %b", k, bus.dtack, (k == 3) ? 1'b0 : 1'b1); end
        end
        bus.step_btn = 1'b0;
        bus.as = 1'b1;
        tick();
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL step_release: got %b want 1", bus.dtack); end
        end_cycle();
        // Second press with no cycle in progress must do nothing.
        bus.step_btn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL step_idle_press edge %0d: got %b want 1", k, bus.dtack); end
        end
        bus.step_btn    = 1'b0;
        bus.single_step = 1'b0;
        end_cycle();
        $display("[TB] test_single_step done");
    endtask

    task automatic test_back_to_back();
        bus.as = 1'b0; bus.uds = 1'b0; bus.ram_select1 = 1'b0;
        tick();
        tick();
        tests++; if (bus.dtack !== 1'b0) begin fails++; $display("FAIL b2b_first_ack: got %b want 0", bus.dtack); end
        bus.as = 1'b1;
        tick();
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL b2b_first_release: got %b want 1", bus.dtack); end
        // as drops again without an IDLE edge at as high: not a new cycle.
        bus.as = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL b2b_unarmed edge %0d: got %b want 1", k, bus.dtack); end
        end
        bus.as = 1'b1;
        tick();
        bus.as = 1'b0;
        tick();
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL b2b_second_start: got %b want 1", bus.dtack); end
        tick();
        tests++; if (bus.dtack !== 1'b0) begin fails++; $display("FAIL b2b_second_ack: got %b want 0", bus.dtack); end
        end_cycle();
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_reset_abort();
        bus.as = 1'b0; bus.uds = 1'b0; bus.ram_select2 = 1'b0;
        tick();
        tick();
        tests++; if (bus.dtack !== 1'b0) begin fails++; $display("FAIL rst_pre_ack: got %b want 0", bus.dtack); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (bus.dtack !== 1'b1) begin fails++; $display("FAIL rst_async_dtack: got %b want 1", bus.dtack); end
        idle_bus();
        tick();
        reset = 1'b0;
        tick();
        // Normal cycle after release.
        bus.as = 1'b0; bus.uds = 1'b0; bus.ram_select2 = 1'b0;
        tick();
        tick();
        tests++; if (bus.dtack !== 1'b0) begin fails++; $display("FAIL rst_after_ack: got %b want 0", bus.dtack); end
        end_cycle();
        // ROM cycle aborted while still waiting.
        bus.as = 1'b0; bus.uds = 1'b0; bus.rom_select = 1'b0;
        tick();
        tick();
        bus.as = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++; if (bus.dtack !== 1'b1 || bus.berr !== 1'b1 || bus.vpa !== 1'b1) begin fails++; $display("FAIL abort_outputs edge %0d: got %b%b%b want 111", k, bus.dtack, bus.berr, bus.vpa); end
        end
        end_cycle();
        $display("[TB] test_reset_abort done");
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_ram(2);
        test_ram(1);
        test_priority();
        test_unmapped();
        test_iack();
        test_single_step();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
